// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb
//
// Dynamic branch predictor for the IF stage. A direct-mapped BTB with a 2-bit
// saturating counter per entry, plus an optional gshare index mode where the
// global history register is XORed into the index.
//
// Ports:
//   clk, rstn          clock / asynchronous active-low reset
//   if_pc              PC being fetched
//   pred_taken         combinational prediction for if_pc
//   pred_target        predicted next PC (if_pc+4 when not taken)
//   pred_ghr           GHR snapshot used for this lookup
//   upd_*              resolved branch/jump from the execute side
//   btb_flush          synchronous invalidate of all entries (also clears GHR)
//   upd_mispredict     combinational mispredict flag for the current update
//   perf_branches      number of update cycles (wraps)
//   perf_mispredicts   number of mispredicted updates (wraps)
// -----------------------------------------------------------------------------
module branch_predictor_btb #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 16,
  parameter int USE_GSHARE  = 0,
  localparam int IDX        = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  output logic [IDX-1:0]        pred_ghr,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [DATA_WIDTH-1:0] upd_pred_target,
  input  logic [IDX-1:0]        upd_ghr,
  input  logic                  btb_flush,
  output logic                  upd_mispredict,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
);

  localparam int TAG_W = DATA_WIDTH - IDX - 2;

  // Entry storage
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]       tag_q    [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_q [NUM_ENTRIES];
  logic [1:0]             ctr_q    [NUM_ENTRIES];

  logic [IDX-1:0] ghr_q, ghr_d;
  logic [31:0]    perf_br_q, perf_br_d;
  logic [31:0]    perf_mp_q, perf_mp_d;

  // Instruction-word offset bits never take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [IDX-1:0]   li;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;

  assign li          = if_pc[IDX+1:2] ^ ((USE_GSHARE != 0) ? ghr_q : '0);
  assign l_tag       = if_pc[DATA_WIDTH-1:IDX+2];
  assign l_hit       = valid_q[li] && (tag_q[li] == l_tag);
  // Jumps predict taken regardless of the counter state.
  assign pred_taken  = l_hit && (jump_q[li] || ctr_q[li][1]);
  assign pred_target = pred_taken ? target_q[li] : (if_pc + DATA_WIDTH'(4));
  assign pred_ghr    = ghr_q;

  // ---------------------------------------------------------------- update
  logic [IDX-1:0]   ui;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             entry_we;
  logic [1:0]       ctr_new;

  assign ui    = upd_pc[IDX+1:2] ^ ((USE_GSHARE != 0) ? upd_ghr : '0);
  assign u_tag = upd_pc[DATA_WIDTH-1:IDX+2];
  assign u_hit = valid_q[ui] && (tag_q[ui] == u_tag);

  // Not-taken misses never allocate; flush suppresses any write.
  assign entry_we = upd_valid && !btb_flush && (upd_taken || u_hit);

  always_comb begin
    ctr_new = ctr_q[ui];
    if (upd_taken) begin
      if (!u_hit)                ctr_new = 2'd2;
      else if (ctr_q[ui] != 2'd3) ctr_new = ctr_q[ui] + 2'd1;
    end else if (u_hit && ctr_q[ui] != 2'd0) begin
      ctr_new = ctr_q[ui] - 2'd1;
    end
  end

  assign upd_mispredict = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));

  always_comb begin
    ghr_d = ghr_q;
    if (btb_flush) begin
      ghr_d = '0;
    end else if ((USE_GSHARE != 0) && upd_valid && !upd_is_jump) begin
      ghr_d = {ghr_q[IDX-2:0], upd_taken};
    end
  end

  assign perf_br_d = perf_br_q + {31'd0, upd_valid};
  assign perf_mp_d = perf_mp_q + {31'd0, upd_mispredict};

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q   <= '0;
      jump_q    <= '0;
      ghr_q     <= '0;
      perf_br_q <= '0;
      perf_mp_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd1;
      end
    end else begin
      ghr_q     <= ghr_d;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
      if (btb_flush) begin
        valid_q <= '0;
      end else if (entry_we) begin
        ctr_q[ui] <= ctr_new;
        if (upd_taken) begin
          valid_q[ui]  <= 1'b1;
          tag_q[ui]    <= u_tag;
          target_q[ui] <= upd_target;
          jump_q[ui]   <= upd_is_jump;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed testbench for branch_predictor_btb. Two instances share all inputs:
// d0 uses the plain PC index, d1 uses gshare indexing.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken, btb_flush;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [3:0]  upd_ghr;

  logic        pt0, pt1, mis0, mis1;
  logic [31:0] tg0, tg1, pb0, pb1, pm0, pm1;
  logic [3:0]  gh0, gh1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.DATA_WIDTH(32), .NUM_ENTRIES(16), .USE_GSHARE(0)) d0 (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pt0), .pred_target(tg0), .pred_ghr(gh0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .upd_ghr(upd_ghr), .btb_flush(btb_flush), .upd_mispredict(mis0),
    .perf_branches(pb0), .perf_mispredicts(pm0)
  );

  branch_predictor_btb #(.DATA_WIDTH(32), .NUM_ENTRIES(16), .USE_GSHARE(1)) d1 (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pt1), .pred_target(tg1), .pred_ghr(gh1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .upd_ghr(upd_ghr), .btb_flush(btb_flush), .upd_mispredict(mis1),
    .perf_branches(pb1), .perf_mispredicts(pm1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One update cycle; mis/pt_now are sampled before the clock edge.
  task automatic upd(input logic [31:0] pc, input logic j, input logic t,
                     input logic [31:0] tgt, input logic pt,
                     input logic [31:0] ptgt, input logic [3:0] ghr,
                     input logic fl, output logic mis, output logic pt_now);
    @(negedge clk);
    upd_pc = pc; upd_is_jump = j; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt; upd_ghr = ghr;
    btb_flush = fl; upd_valid = 1'b1;
    #1;
    mis    = mis0;
    pt_now = pt0;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    btb_flush = 1'b0;
  endtask

  // Update with a checked mispredict flag.
  task automatic tr(input string tag, input logic [31:0] pc, input logic j,
                    input logic t, input logic [31:0] tgt, input logic pt,
                    input logic [31:0] ptgt, input logic [3:0] ghr,
                    input logic exp_mis);
    logic m, p;
    upd(pc, j, t, tgt, pt, ptgt, ghr, 1'b0, m, p);
    check(tag, {31'd0, m}, {31'd0, exp_mis});
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    if_pc = pc;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic m, p;
    rstn = 1'b0; if_pc = 32'h40;
    upd_valid = 0; upd_is_jump = 0; upd_taken = 0; upd_pred_taken = 0;
    btb_flush = 0; upd_pc = 0; upd_target = 0; upd_pred_target = 0; upd_ghr = 0;
    #1;
    check("rst_pred_taken",  {31'd0, pt0}, 32'd0);
    check("rst_pred_target", tg0, 32'h44);
    check("rst_perf_br",     pb0, 32'd0);
    check("rst_perf_mp",     pm0, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // First taken training; same-cycle lookup must still see the old entry.
    if_pc = 32'h40;
    upd(32'h40, 0, 1, 32'h100, 0, 32'h44, 4'h0, 0, m, p);
    check("first_mispredict", {31'd0, m}, 32'd1);
    check("no_bypass",        {31'd0, p}, 32'd0);
    look(32'h40);
    check("trained_taken",  {31'd0, pt0}, 32'd1);
    check("trained_target", tg0, 32'h100);
    check("perf_mp_1",      pm0, 32'd1);
    check("perf_br_1",      pb0, 32'd1);

    // Hysteresis: counter 2 -> 3 (saturate) -> 2 -> 1
    for (int i = 0; i < 3; i++)
      tr("hyst_taken_mis", 32'h40, 0, 1, 32'h100, 1, 32'h100, 4'h0, 0);
    tr("hyst_nt1_mis", 32'h40, 0, 0, 32'h0, 1, 32'h100, 4'h0, 1);
    look(32'h40);
    check("hyst_still_taken", {31'd0, pt0}, 32'd1);
    tr("hyst_nt2_mis", 32'h40, 0, 0, 32'h0, 1, 32'h100, 4'h0, 1);
    look(32'h40);
    check("hyst_now_nt",     {31'd0, pt0}, 32'd0);
    check("hyst_nt_target",  tg0, 32'h44);

    // Aliasing: 0x40 and 0x80 share index 0 with different tags.
    tr("alias_40_mis", 32'h40, 0, 1, 32'h100, 0, 32'h44, 4'h0, 1);
    look(32'h40);
    check("alias_40_taken", {31'd0, pt0}, 32'd1);
    tr("alias_80_mis", 32'h80, 0, 1, 32'h180, 0, 32'h84, 4'h0, 1);
    look(32'h40);
    check("alias_40_miss",   {31'd0, pt0}, 32'd0);
    check("alias_40_target", tg0, 32'h44);
    look(32'h80);
    check("alias_80_hit",    {31'd0, pt0}, 32'd1);
    check("alias_80_target", tg0, 32'h180);
    // Taken with a wrong predicted target is a mispredict and retargets.
    tr("target_mis", 32'h80, 0, 1, 32'h1C0, 1, 32'h180, 4'h0, 1);
    look(32'h80);
    check("retarget", tg0, 32'h1C0);

    // jal at 0x200 (also index 0, evicts 0x80)
    tr("jal_mis", 32'h200, 1, 1, 32'h300, 0, 32'h204, 4'h0, 1);
    for (int i = 0; i < 5; i++)
      tr("nt_elsewhere_mis", 32'h204, 0, 0, 32'h0, 0, 32'h208, 4'h0, 0);
    // Drive the counter to 0; the jump bit must keep it predicted taken.
    tr("jal_dec_mis", 32'h200, 0, 0, 32'h0, 1, 32'h300, 4'h0, 1);
    tr("jal_dec_mis", 32'h200, 0, 0, 32'h0, 1, 32'h300, 4'h0, 1);
    look(32'h200);
    check("jal_taken",  {31'd0, pt0}, 32'd1);
    check("jal_target", tg0, 32'h300);
    look(32'h80);
    check("evicted_80", {31'd0, pt0}, 32'd0);
    check("perf_br_17", pb0, 32'd17);
    check("perf_mp_9",  pm0, 32'd9);
    check("d0_ghr_zero", {28'd0, gh0}, 32'd0);

    // Flush together with a taken update: flush wins, perf still counts.
    upd(32'h300, 0, 1, 32'h400, 0, 32'h304, 4'h0, 1, m, p);
    check("flush_upd_mis", {31'd0, m}, 32'd1);
    look(32'h200);
    check("flush_miss_200", {31'd0, pt0}, 32'd0);
    look(32'h300);
    check("flush_miss_300", {31'd0, pt0}, 32'd0);
    check("flush_target",   tg0, 32'h304);
    check("perf_br_18",     pb0, 32'd18);
    check("perf_mp_10",     pm0, 32'd10);

    // Reset asserted mid-training.
    tr("pre_rst_mis", 32'h40, 0, 1, 32'h100, 0, 32'h44, 4'h0, 1);
    look(32'h40);
    check("pre_rst_taken", {31'd0, pt0}, 32'd1);
    @(negedge clk);
    upd_pc = 32'h40; upd_is_jump = 0; upd_taken = 1; upd_target = 32'h140;
    upd_pred_taken = 0; upd_pred_target = 32'h44; upd_ghr = 0; upd_valid = 1;
    #2 rstn = 1'b0;
    #1;
    check("midrst_taken",   {31'd0, pt0}, 32'd0);
    check("midrst_target",  tg0, 32'h44);
    check("midrst_perf_br", pb0, 32'd0);
    check("midrst_perf_mp", pm0, 32'd0);
    @(negedge clk);
    upd_valid = 0;
    rstn = 1'b1;
    look(32'h40);
    check("postrst_taken",   {31'd0, pt0}, 32'd0);
    check("postrst_perf_br", pb0, 32'd0);

    // Gshare: build GHR to 0xF with taken branches indexed at GHR 0.
    for (int i = 0; i < 4; i++)
      tr("gs_fill_mis", 32'h40, 0, 1, 32'h100, 1, 32'h100, 4'h0, 0);
    check("gs_ghr_f", {28'd0, gh1}, 32'hF);
    check("d0_ghr_held", {28'd0, gh0}, 32'd0);
    look(32'h40);
    check("gs_f_miss",   {31'd0, pt1}, 32'd0);
    check("gs_f_target", tg1, 32'h44);
    tr("gs_f_train_mis", 32'h40, 0, 1, 32'h500, 0, 32'h44, 4'hF, 1);
    look(32'h40);
    check("gs_f_hit_target", tg1, 32'h500);
    for (int i = 0; i < 4; i++)
      tr("gs_drain_mis", 32'h44, 0, 0, 32'h0, 0, 32'h48, 4'h0, 0);
    check("gs_ghr_0", {28'd0, gh1}, 32'd0);
    look(32'h40);
    check("gs_0_taken",  {31'd0, pt1}, 32'd1);
    check("gs_0_target", tg1, 32'h100);
    tr("gs_jal_mis", 32'h208, 1, 1, 32'h600, 0, 32'h20C, 4'h0, 1);
    check("gs_jal_no_shift", {28'd0, gh1}, 32'd0);
    tr("gs_br_mis", 32'h44, 0, 1, 32'h700, 0, 32'h48, 4'h0, 1);
    check("gs_ghr_1", {28'd0, gh1}, 32'd1);
    @(negedge clk);
    btb_flush = 1'b1;
    @(posedge clk);
    #1 btb_flush = 1'b0;
    check("gs_flush_ghr", {28'd0, gh1}, 32'd0);
    look(32'h40);
    check("gs_flush_miss", {31'd0, pt1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
